// File: rtl/mem_refill_ctrl.sv
// -----------------------------------------------------------------------------
// mem_refill_ctrl
//
// Memory-stage miss sequencer. Watches the data-cache tag compare for the
// instruction in MEM. On a miss it holds the MEM/WB register (pipe_adv low),
// fetches the whole cache line from main memory with a request/acknowledge
// handshake followed by a burst of valid words, streams those words into the
// cache data array, and releases the pipeline once the line is resident.
//
// Parameters:
//   LINE_WORDS  words per cache line (power of two, >= 2)
//   IDX_W       log2(LINE_WORDS), width of the word index
//
// Ports:
//   clk          controller clock, state updates on posedge
//   rstn         asynchronous active-low reset
//   mem_access   MEM-stage instruction is a load or store
//   cache_hit    tag compare matched for the MEM-stage address
//   miss_addr    byte address of the MEM-stage access
//   pipe_adv     advance enable to the MEM/WB register (sampled on negedge)
//   mem_req      line-fetch request, held until mem_ack
//   mem_addr     line-aligned fetch address (0 outside the request phase)
//   mem_ack      memory accepted the request
//   mem_rvalid   one refill word valid on mem_rdata
//   mem_rdata    refill data word
//   fill_we      write strobe to the cache data array
//   fill_idx     word index within the line for fill_we
//   fill_data    word to write (straight from mem_rdata)
//   fill_done    one-cycle pulse once the line is complete
//   busy         high whenever a refill is in progress
//   stall_cycles (only with STALL_CNT_EN) saturating count of stalled cycles
//
// Build option: define STALL_CNT_EN to add the stall_cycles output and its
// saturating counter. Without it the port and counter are absent.
// -----------------------------------------------------------------------------
module mem_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             mem_access,
    input  logic             cache_hit,
    input  logic [31:0]      miss_addr,
    output logic             pipe_adv,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             fill_we,
    output logic [IDX_W-1:0] fill_idx,
    output logic [31:0]      fill_data,
    output logic             fill_done,
`ifdef STALL_CNT_EN
    output logic [31:0]      stall_cycles,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Byte-offset bits covered by one line (word index plus byte-in-word).
    localparam int               OFF_W    = IDX_W + 2;
    localparam logic [31:0]      OFF_MASK = 32'((64'd1 << OFF_W) - 64'd1);
    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(LINE_WORDS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      line_q,  line_d;

    logic             miss_s;
    logic [31:0]      line_addr_s;

    assign miss_s      = mem_access && !cache_hit;
    assign line_addr_s = miss_addr & ~OFF_MASK;

    // The data path to the cache array is a direct pass-through; only the
    // strobe is qualified. The counter is 0 outside FILL (cleared on ack,
    // wraps to 0 on the last word), so fill_idx needs no extra gating.
    assign fill_idx  = cnt_q;
    assign fill_data = mem_rdata;

    // Next-state and output decode for the refill sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        pipe_adv  = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = 32'd0;
        fill_we   = 1'b0;
        fill_done = 1'b0;
        busy      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                busy     = 1'b0;
                // Combinational so the stall reaches the MEM/WB register in
                // the same cycle the miss is seen.
                pipe_adv = !miss_s;
                if (miss_s) begin
                    line_d  = line_addr_s;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_REQ: begin
                mem_req  = 1'b1;
                mem_addr = line_q;
                // mem_rvalid is deliberately not looked at here, even in the
                // ack cycle: data only counts once we are in FILL.
                if (mem_ack) begin
                    cnt_d   = {IDX_W{1'b0}};
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_REQ;
                end
            end

            ST_FILL: begin
                if (mem_rvalid) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + IDX_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end

            ST_DONE: begin
                // A miss seen here is left for IDLE to pick up next cycle.
                fill_done = 1'b1;
                state_d   = ST_IDLE;
            end

            default: begin
                busy    = 1'b0;
                cnt_d   = {IDX_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, word counter and latched line address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= {IDX_W{1'b0}};
            line_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    assign stall_cycles = stall_q;

    // Saturating count of posedges at which the pipeline was held.
    always_comb begin
        if (!pipe_adv && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mem_refill_ctrl (LINE_WORDS=4). A transaction-level
// model (miss pending / acknowledged / words received / line complete) predicts
// every output; it is compared on every negedge. Directed scenarios add
// hand-computed literal expectations; a long randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mem_refill_ctrl;

    localparam int LW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          mem_access;
    logic          cache_hit;
    logic [31:0]   miss_addr;
    logic          pipe_adv;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          fill_we;
    logic [IW-1:0] fill_idx;
    logic [31:0]   fill_data;
    logic          fill_done;
    logic          busy;
`ifdef STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    always #5 clk = ~clk;

    mem_refill_ctrl #(.LINE_WORDS(LW), .IDX_W(IW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .mem_access (mem_access),
        .cache_hit  (cache_hit),
        .miss_addr  (miss_addr),
        .pipe_adv   (pipe_adv),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .fill_we    (fill_we),
        .fill_idx   (fill_idx),
        .fill_data  (fill_data),
        .fill_done  (fill_done),
`ifdef STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .busy       (busy)
    );

    int tests = 0;
    int fails = 0;

    // Transaction-level reference model.
    bit          m_busy;    // a line refill is outstanding
    bit          m_acked;   // memory has accepted the request
    bit          m_done;    // all words received, completion cycle pending
    int          m_words;   // words received so far
    logic [31:0] m_line;
    logic [31:0] m_stall;

    // Observations gathered during a directed scenario.
    int          cap_low, cap_done, cap_we, cap_req;
    logic [31:0] cap_addr;
    int          cap_idx[$];
    logic [31:0] cap_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_pipe_adv();
        if (!rstn || !m_busy) return !(mem_access && !cache_hit);
        return 1'b0;
    endfunction

    task automatic clear_cap();
        cap_low = 0; cap_done = 0; cap_we = 0; cap_req = 0; cap_addr = 32'd0;
        cap_idx.delete();
        cap_data.delete();
    endtask

    // Compare every output against the model, then record observations.
    task automatic check_outputs();
        bit req, fill, fin;
        req  = rstn && m_busy && !m_acked;
        fill = rstn && m_busy && m_acked && !m_done;
        fin  = rstn && m_busy && m_done;
        chk("pipe_adv",  32'(pipe_adv),  32'(exp_pipe_adv()));
        chk("busy",      32'(busy),      32'(rstn && m_busy));
        chk("mem_req",   32'(mem_req),   32'(req));
        chk("mem_addr",  mem_addr,       req ? m_line : 32'd0);
        chk("fill_we",   32'(fill_we),   32'(fill && mem_rvalid));
        chk("fill_idx",  32'(fill_idx),  fill ? 32'(m_words) : 32'd0);
        if (fill && mem_rvalid) chk("fill_data", fill_data, mem_rdata);
        chk("fill_done", 32'(fill_done), 32'(fin));
`ifdef STALL_CNT_EN
        chk("stall_cycles", stall_cycles, m_stall);
`endif
        if (rstn && pipe_adv === 1'b0) cap_low++;
        if (fill_we === 1'b1) begin
            cap_we++;
            cap_idx.push_back(int'(fill_idx));
            cap_data.push_back(fill_data);
        end
        if (fill_done === 1'b1) cap_done++;
        if (mem_req === 1'b1) begin
            cap_req++;
            cap_addr = mem_addr;
        end
    endtask

    // Advance the model across one posedge using the inputs present there.
    task automatic update_model();
        if (!rstn) begin
            m_busy = 0; m_acked = 0; m_done = 0; m_words = 0; m_stall = 32'd0;
        end else begin
            if (!exp_pipe_adv() && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (!m_busy) begin
                if (mem_access && !cache_hit) begin
                    m_busy = 1; m_acked = 0; m_done = 0; m_words = 0;
                    m_line = miss_addr - (miss_addr % 32'(LW * 4));
                end
            end else if (!m_acked) begin
                if (mem_ack) m_acked = 1;
            end else if (!m_done) begin
                if (mem_rvalid) begin
                    m_words++;
                    if (m_words == LW) m_done = 1;
                end
            end else begin
                m_busy = 0; m_acked = 0; m_done = 0; m_words = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    // Zero-wait miss: ack immediately, a word every cycle, hit from cycle 6.
    task automatic zero_wait_miss(input logic [31:0] addr);
        miss_addr = addr; mem_access = 1'b1; cache_hit = 1'b0;
        mem_ack = 1'b1; mem_rvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mem_rdata = 32'hA0 + 32'(m_words);
            cache_hit = (i >= 6);
            tick();
        end
        mem_ack = 1'b0; mem_rvalid = 1'b0;
    endtask

    initial begin
        m_busy = 0; m_acked = 0; m_done = 0; m_words = 0;
        m_line = 32'd0; m_stall = 32'd0;
        clear_cap();

        // ---- reset behaviour ----
        rstn = 1'b0; mem_access = 1'b1; cache_hit = 1'b1; miss_addr = 32'h0000_1234;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        tick();
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_mem_req",  32'(mem_req),  32'd0);
        chk("rst_fill_we",  32'(fill_we),  32'd0);
        chk("rst_pipe_adv", 32'(pipe_adv), 32'd1);
        cache_hit = 1'b0;
        tick();
        chk("rst_miss_pipe_adv", 32'(pipe_adv), 32'd0);
        tick();
        chk("rst_miss_busy", 32'(busy), 32'd0);
        cache_hit = 1'b1; rstn = 1'b1;
        tick(); tick();

        // ---- zero-wait miss, stray rvalid alongside ack ----
        clear_cap();
        zero_wait_miss(32'h0000_1234);
        chk("zw_addr",     cap_addr,       32'h0000_1230);
        chk("zw_req_cyc",  32'(cap_req),   32'd1);
        chk("zw_low_cyc",  32'(cap_low),   32'd7);
        chk("zw_done_cnt", 32'(cap_done),  32'd1);
        chk("zw_we_cnt",   32'(cap_we),    32'd4);
        for (int k = 0; k < 4 && k < cap_idx.size(); k++) begin
            chk("zw_idx",  32'(cap_idx[k]), 32'(k));
            chk("zw_data", cap_data[k],     32'hA0 + 32'(k));
        end
        chk("zw_pipe_adv_after", 32'(pipe_adv), 32'd1);
`ifdef STALL_CNT_EN
        chk("zw_stall_cycles", stall_cycles, 32'd7);
`endif

        // ---- slow memory: ack on 3rd request cycle, 2-cycle gaps ----
        begin
            int  req_cnt, fill_cnt;
            bit  was_req, was_fill;
            req_cnt = 0; fill_cnt = 0;
            clear_cap();
            miss_addr = 32'hDEAD_BEEF; mem_access = 1'b1; cache_hit = 1'b0;
            for (int n = 0; n < 60; n++) begin
                was_req  = m_busy && !m_acked;
                was_fill = m_busy && m_acked && !m_done;
                mem_ack    = was_req && (req_cnt == 2);
                mem_rvalid = was_fill && (fill_cnt % 3 == 0);
                mem_rdata  = $urandom;
                if (m_done) cache_hit = 1'b1;
                tick();
                if (was_req)  req_cnt++;
                if (was_fill) fill_cnt++;
                if (cap_done != 0 && !m_busy) break;
            end
            mem_ack = 1'b0; mem_rvalid = 1'b0; cache_hit = 1'b1;
            chk("slow_addr",     cap_addr,      32'hDEAD_BEE0);
            chk("slow_req_cyc",  32'(cap_req),  32'd3);
            chk("slow_we_cnt",   32'(cap_we),   32'd4);
            chk("slow_done_cnt", 32'(cap_done), 32'd1);
            chk("slow_low_cyc",  32'(cap_low),  32'd15);
            for (int k = 0; k < 4 && k < cap_idx.size(); k++)
                chk("slow_idx", 32'(cap_idx[k]), 32'(k));
            tick();
        end

        // ---- reset mid-fill, then refetch from word 0 ----
        miss_addr = 32'h0000_4008; mem_access = 1'b1; cache_hit = 1'b0;
        mem_ack = 1'b1; mem_rvalid = 1'b1;
        for (int n = 0; n < 20 && m_words < 2; n++) begin
            mem_rdata = $urandom;
            tick();
        end
        rstn = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_fill_we", 32'(fill_we), 32'd0);
        chk("midrst_busy",    32'(busy),    32'd0);
        tick();
        rstn = 1'b1;
        clear_cap();
        zero_wait_miss(32'h0000_4008);
        chk("refetch_addr",     cap_addr,      32'h0000_4000);
        chk("refetch_we_cnt",   32'(cap_we),   32'd4);
        chk("refetch_done_cnt", 32'(cap_done), 32'd1);
        if (cap_idx.size() > 0) chk("refetch_first_idx", 32'(cap_idx[0]), 32'd0);
        else chk("refetch_first_idx", 32'hFFFF_FFFF, 32'd0);

        // ---- randomized traffic with occasional resets ----
        for (int n = 0; n < 3000; n++) begin
            rstn       = ($urandom_range(0, 199) != 0);
            mem_access = 1'($urandom_range(0, 1));
            cache_hit  = ($urandom_range(0, 9) < 7);
            miss_addr  = $urandom;
            mem_ack    = ($urandom_range(0, 3) == 0);
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
